// File: rtl/dragon_fireball.sv
// Dragon fireball sprite controller: random launch from the dragon, ballistic flight,
// explosion on player hit, then a cooldown before the next shot.
module dragon_fireball #(
   parameter int Y_SPEED          = 160,
   parameter int X_DRIFT          = -40,
   parameter int LAUNCH_THRESHOLD = 40,
   parameter int SPAWN_DX         = 2,
   parameter int SPAWN_DY         = 48,
   parameter int FLOOR_Y          = 440,
   parameter int EXPLODE_FRAMES   = 8,
   parameter int COOLDOWN_FRAMES  = 30
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               pause,
   input  logic [10:0]        RNG,
   input  logic signed [10:0] dragonTLX,
   input  logic signed [10:0] dragonTLY,
   input  logic               collision,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY,
   output logic               fireballActive,
   output logic               exploding
);

   localparam int unsigned POS_W   = 32;
   localparam int unsigned FRAC_W  = 6;
   localparam int unsigned PIX_W   = 11;
   localparam int unsigned CNT_MAX = (EXPLODE_FRAMES > COOLDOWN_FRAMES) ?
                                     unsigned'(EXPLODE_FRAMES) : unsigned'(COOLDOWN_FRAMES);
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic signed [POS_W-1:0] PARK_X = POS_W'(700 * 64);
   localparam logic signed [POS_W-1:0] PARK_Y = '0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLYING   = 2'd1,
      EXPLODE  = 2'd2,
      COOLDOWN = 2'd3
   } state_e;

   state_e                   state_q, state_d;
   logic signed [POS_W-1:0]  x_q, x_d;
   logic signed [POS_W-1:0]  y_q, y_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     coll_q, coll_d;
   logic                     active_q, explode_q;

   logic                     update;
   logic                     hit;
   logic                     visible;
   logic                     launch;
   logic                     off_field;
   logic signed [POS_W-1:0]  pos_x, pos_y;
   logic signed [POS_W-1:0]  spawn_x, spawn_y;

   // Pixel position and event decodes used by the next-state logic
   always_comb begin
      update    = startOfFrame & ~pause;
      hit       = coll_q | (collision & (state_q == FLYING));
      pos_x     = x_q >>> FRAC_W;
      pos_y     = y_q >>> FRAC_W;
      visible   = (dragonTLX >= 11'sd0) && (dragonTLX <= 11'sd639);
      launch    = visible && (32'(RNG) < unsigned'(LAUNCH_THRESHOLD));
      off_field = (pos_y > FLOOR_Y) || (pos_x < -16);
      spawn_x   = (POS_W'(dragonTLX) + SPAWN_DX) <<< FRAC_W;
      spawn_y   = (POS_W'(dragonTLY) + SPAWN_DY) <<< FRAC_W;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         x_q       <= PARK_X;
         y_q       <= PARK_Y;
         cnt_q     <= '0;
         coll_q    <= 1'b0;
         active_q  <= 1'b0;
         explode_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         cnt_q     <= cnt_d;
         coll_q    <= coll_d;
         active_q  <= (state_d == FLYING);
         explode_q <= (state_d == EXPLODE);
      end
   end

   // Between updates the hit latch accumulates; every update consumes and clears it
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      coll_d  = hit;
      if (update) begin
         coll_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  state_d = FLYING;
                  x_d     = spawn_x;
                  y_d     = spawn_y;
               end
            end
            FLYING: begin
               if (hit) begin
                  state_d = EXPLODE;
                  cnt_d   = CNT_W'(EXPLODE_FRAMES - 1);
               end else if (off_field) begin
                  state_d = COOLDOWN;
                  cnt_d   = CNT_W'(COOLDOWN_FRAMES - 1);
                  x_d     = PARK_X;
                  y_d     = PARK_Y;
               end else begin
                  x_d = x_q + POS_W'(X_DRIFT);
                  y_d = y_q + POS_W'(Y_SPEED);
               end
            end
            EXPLODE: begin
               if (cnt_q == '0) begin
                  state_d = COOLDOWN;
                  cnt_d   = CNT_W'(COOLDOWN_FRAMES - 1);
                  x_d     = PARK_X;
                  y_d     = PARK_Y;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            COOLDOWN: begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign topLeftX       = PIX_W'(pos_x);
   assign topLeftY       = PIX_W'(pos_y);
   assign fireballActive = active_q;
   assign exploding      = explode_q;

endmodule

// File: tb/tb_dragon_fireball.sv
// Directed scoreboard bench for dragon_fireball: launch, flight, hit, pause,
// floor/edge exits, cooldown timing and asynchronous reset.
module tb_dragon_fireball;

   logic               clk = 1'b0;
   logic               resetN;
   logic               startOfFrame;
   logic               pause;
   logic [10:0]        RNG;
   logic signed [10:0] dragonTLX;
   logic signed [10:0] dragonTLY;
   logic               collision;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic               fireballActive;
   logic               exploding;

   always #5 clk = ~clk;

   dragon_fireball dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .pause          (pause),
      .RNG            (RNG),
      .dragonTLX      (dragonTLX),
      .dragonTLY      (dragonTLY),
      .collision      (collision),
      .topLeftX       (topLeftX),
      .topLeftY       (topLeftY),
      .fireballActive (fireballActive),
      .exploding      (exploding)
   );

   typedef struct {
      string tag;
      logic  fa;
      logic  ex;
      int    x;
      int    y;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   fx;
   int   fy;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push(input string tag, input logic fa, input logic ex,
                       input int x, input int y);
      exp_t e;
      e.tag = tag;
      e.fa  = fa;
      e.ex  = ex;
      e.x   = x;
      e.y   = y;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_active"},    32'(fireballActive), 32'(e.fa));
         chk({e.tag, "_exploding"}, 32'(exploding),      32'(e.ex));
         chk({e.tag, "_x"},         32'(topLeftX),       e.x);
         chk({e.tag, "_y"},         32'(topLeftY),       e.y);
      end
   endtask

   task automatic gap();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One frame pulse, optionally with a coincident collision
   task automatic frame(input logic coll);
      gap();
      startOfFrame = 1'b1;
      collision    = coll;
      @(posedge clk);
      #1;
      startOfFrame = 1'b0;
      collision    = 1'b0;
   endtask

   task automatic step(input string tag, input logic fa, input logic ex,
                       input int x, input int y, input logic coll);
      push(tag, fa, ex, x, y);
      frame(coll);
      pop_check();
   endtask

   task automatic mid_collision();
      gap();
      collision = 1'b1;
      @(posedge clk);
      #1;
      collision = 1'b0;
   endtask

   task automatic pulse_reset();
      resetN = 1'b0;
      @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   initial begin
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      pause        = 1'b0;
      collision    = 1'b0;
      RNG          = 11'd2000;
      dragonTLX    = 11'sd300;
      dragonTLY    = 11'sd100;
      repeat (3) @(posedge clk);
      #1;
      push("reset", 1'b0, 1'b0, 700, 0);
      pop_check();
      resetN = 1'b1;

      // No launch: threshold boundary, off-screen dragon, right-edge boundary
      RNG = 11'd40;
      repeat (10) step("nolaunch_rng40", 1'b0, 1'b0, 700, 0, 1'b0);
      RNG       = 11'd0;
      dragonTLX = -11'sd20;
      repeat (10) step("nolaunch_offscreen", 1'b0, 1'b0, 700, 0, 1'b0);
      dragonTLX = 11'sd640;
      repeat (3) step("nolaunch_x640", 1'b0, 1'b0, 700, 0, 1'b0);

      // Launch and flight
      dragonTLX = 11'sd300;
      RNG       = 11'd10;
      fx = 302 * 64;
      fy = 148 * 64;
      step("launch", 1'b1, 1'b0, 302, 148, 1'b0);
      RNG = 11'd2000;
      fx -= 40; fy += 160;
      step("fly1", 1'b1, 1'b0, fx >>> 6, fy >>> 6, 1'b0);
      fx -= 40; fy += 160;
      step("fly2", 1'b1, 1'b0, 300, 153, 1'b0);

      // Mid-frame hit: 8 frames of explosion, then 30 of cooldown, then idle
      mid_collision();
      repeat (8) step("explode", 1'b0, 1'b1, 300, 153, 1'b0);
      RNG = 11'd0;
      repeat (30) step("cooldown", 1'b0, 1'b0, 700, 0, 1'b0);
      step("cooldown_to_idle", 1'b0, 1'b0, 700, 0, 1'b0);
      fx = 302 * 64;
      fy = 148 * 64;
      step("relaunch", 1'b1, 1'b0, 302, 148, 1'b0);
      RNG = 11'd2000;
      fx -= 40; fy += 160;
      step("fly_pre_pause", 1'b1, 1'b0, fx >>> 6, fy >>> 6, 1'b0);

      // Pause freezes motion; a collision during pause is honoured on resume
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) mid_collision();
         step("paused", 1'b1, 1'b0, fx >>> 6, fy >>> 6, 1'b0);
      end
      pause = 1'b0;
      step("pause_explode", 1'b0, 1'b1, fx >>> 6, fy >>> 6, 1'b0);
      step("explode_hold", 1'b0, 1'b1, fx >>> 6, fy >>> 6, 1'b0);

      // Asynchronous reset mid-explosion, observed before the next clock edge
      resetN = 1'b0;
      #1;
      push("async_reset", 1'b0, 1'b0, 700, 0);
      pop_check();
      @(posedge clk);
      #1;
      resetN = 1'b1;
      RNG    = 11'd0;
      step("launch_after_reset", 1'b1, 1'b0, 302, 148, 1'b0);

      // Coincident collision and floor condition: explosion wins
      pulse_reset();
      dragonTLY = 11'sd393;
      step("launch_y441", 1'b1, 1'b0, 302, 441, 1'b0);
      RNG = 11'd2000;
      step("simul_explode", 1'b0, 1'b1, 302, 441, 1'b1);

      // Floor boundary: 440 keeps flying, 442 exits
      pulse_reset();
      RNG       = 11'd0;
      dragonTLY = 11'sd392;
      step("launch_y440", 1'b1, 1'b0, 302, 440, 1'b0);
      RNG = 11'd2000;
      step("fly_at_floor", 1'b1, 1'b0, 301, 442, 1'b0);
      step("floor_exit", 1'b0, 1'b0, 700, 0, 1'b0);

      // Left edge exit once X goes below -16
      pulse_reset();
      RNG       = 11'd0;
      dragonTLX = 11'sd0;
      dragonTLY = 11'sd0;
      fx = 2 * 64;
      fy = 48 * 64;
      step("launch_left", 1'b1, 1'b0, 2, 48, 1'b0);
      RNG = 11'd2000;
      for (int i = 0; i < 60; i++) begin
         if ((fx >>> 6) < -16) begin
            step("left_exit", 1'b0, 1'b0, 700, 0, 1'b0);
            break;
         end
         fx -= 40; fy += 160;
         step("fly_left", 1'b1, 1'b0, fx >>> 6, fy >>> 6, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dragon_fireball.md
DRAGON_FIREBALL -- requirements
Module: dragon_fireball

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named `clk` and `resetN`.
REQ-002 Parameters (name, default, meaning), one per line:
- `Y_SPEED`, 160, fall speed in 1/64 px per frame.
- `X_DRIFT`, -40, horizontal speed in 1/64 px per frame.
- `LAUNCH_THRESHOLD`, 40, launch when `RNG < LAUNCH_THRESHOLD`.
- `SPAWN_DX`, 2, X offset from the dragon top-left, in px.
- `SPAWN_DY`, 48, Y offset from the dragon top-left, in px.
- `FLOOR_Y`, 440, fall-off limit in px.
- `EXPLODE_FRAMES`, 8, explosion duration in frames.
- `COOLDOWN_FRAMES`, 30, re-arm delay in frames.
REQ-003 Ports (name, direction, width, meaning), one per line:
- `clk`, in, 1, system clock.
- `resetN`, in, 1, asynchronous active-low reset.
- `startOfFrame`, in, 1, one-cycle pulse per video frame.
- `pause`, in, 1, freezes all motion and counters.
- `RNG`, in, 11, free-running random value.
- `dragonTLX`, in, signed 11, dragon top-left X in px.
- `dragonTLY`, in, signed 11, dragon top-left Y in px.
- `collision`, in, 1, fireball-vs-player hit pulse, may arrive on any cycle.
- `topLeftX`, out, signed 11, fireball top-left X in px.
- `topLeftY`, out, signed 11, fireball top-left Y in px.
- `fireballActive`, out, 1, draw request for the flying sprite.
- `exploding`, out, 1, draw request for the explosion sprite.

Function
REQ-004 The block SHALL hold position in 32-bit signed fixed point with 6 fractional bits, and `topLeftX`/`topLeftY` SHALL be the arithmetic right shift by 6 of the internal X/Y.
REQ-005 The state machine SHALL have the states IDLE, FLYING, EXPLODE and COOLDOWN, and state, position and counters SHALL change only on cycles where `startOfFrame`=1 and `pause`=0.
REQ-006 When `pause`=1 on a `startOfFrame` cycle, state, position and counters SHALL hold unchanged.
REQ-007 The dragon SHALL count as visible when `0 <= dragonTLX <= 639`.
REQ-008 IDLE -> FLYING SHALL occur when the dragon is visible and `RNG < LAUNCH_THRESHOLD` (unsigned compare), loading X = (`dragonTLX` + `SPAWN_DX`)*64 and Y = (`dragonTLY` + `SPAWN_DY`)*64 in the same update.
REQ-009 In FLYING, each update SHALL perform X += `X_DRIFT` and Y += `Y_SPEED`.
REQ-010 FLYING -> EXPLODE SHALL occur when the collision latch is set at the update, with position frozen and the explode counter loaded with `EXPLODE_FRAMES`-1.
REQ-011 FLYING -> COOLDOWN SHALL occur when `topLeftY > FLOOR_Y` or `topLeftX < -16`, evaluated on the pre-update position.
REQ-012 If the collision condition and the floor/edge condition are both true at the same update, EXPLODE SHALL win.
REQ-013 The collision latch SHALL set on any cycle where `collision`=1 and the state is FLYING, clear on every non-paused `startOfFrame` update, and ignore `collision` in all other states.
REQ-014 A `collision` arriving in the same cycle as the update SHALL be included in that update's decision.
REQ-015 EXPLODE SHALL decrement its counter on each update and go to COOLDOWN on the update where the counter equals 0, so the explosion lasts exactly `EXPLODE_FRAMES` updates.
REQ-016 On entry to COOLDOWN the counter SHALL be loaded with `COOLDOWN_FRAMES`-1, and the block SHALL go to IDLE on the update where it equals 0.
REQ-017 `fireballActive` SHALL be 1 only in FLYING and `exploding` SHALL be 1 only in EXPLODE; both are registered state decodes that are never simultaneously 1.
REQ-018 In IDLE and COOLDOWN the internal position SHALL be parked at X = 700*64, Y = 0.
REQ-019 Counters SHALL be wide enough that no wrap occurs for the parameter defaults.

Reset
REQ-020 Asserting `resetN`=0 at any time, including mid-flight or mid-explosion, SHALL immediately force IDLE, clear the collision latch and counters, set X = 700*64 and Y = 0, and drive `fireballActive`=0 and `exploding`=0.
REQ-021 After `resetN` rises, the first possible launch SHALL be on the next non-paused `startOfFrame`.

Verification
REQ-022 Launch: `dragonTLX`=300, `dragonTLY`=100, `RNG`=10, one frame pulse -> FLYING, `topLeftX`=302, `topLeftY`=148; after 2 more frames X=300 (integer part of 302 - 80/64, rounded down), Y=153.
REQ-023 No launch: `RNG`=40, or `dragonTLX`=-20 with `RNG`=0 -> remains IDLE for 10 frames with `fireballActive`=0.
REQ-024 Hit: `collision` pulsed mid-frame while FLYING -> next frame `exploding`=1 with position frozen for 8 frames, then 30 frames of COOLDOWN, then IDLE.
REQ-025 Simultaneous events: `collision` coincident with `startOfFrame` while `topLeftY`=441 -> EXPLODE, not COOLDOWN.
REQ-026 Pause: `pause`=1 for 5 frames while FLYING -> position unchanged; `collision` during pause is latched and causes EXPLODE on the first unpaused frame.
REQ-027 Reset mid-EXPLODE: `resetN`=0 for 1 cycle -> `exploding`=0 in the same cycle and state IDLE; a relaunch is possible on the next frame.
